// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-port byte-addressable data memory with load/store sizing.
// Handles byte/half/word stores with byte-lane enables. Loads are sign- or
// zero-extended and registered. Accesses are checked for alignment and range.
// Every accepted request gets exactly one response pulse on the next cycle.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous reset, active-high
//   req_valid     request present this cycle
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   address       byte address
//   write_data    right-aligned store data
//   read_data     extended load result (0 for stores and errors)
//   resp_valid    response for the request accepted on the previous edge
//   misaligned    previous request misaligned or used the reserved size
//   out_of_range  previous request fell outside the mapped window
module data_mem_lsu #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  resp_valid,
  output logic                  misaligned,
  output logic                  out_of_range
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH_WORDS);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] r_read_data;
  logic        r_resp_valid;
  logic        r_misaligned;
  logic        r_out_of_range;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [WIDX_W-1:0]     w_index;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_lane;
  logic                  w_out_of_range;
  logic                  w_misaligned;
  logic                  w_err;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic                  w_sext;

  // Address decode. The offset wraps in ADDR_WIDTH bits, so the explicit
  // below-base test keeps low addresses from aliasing into the window.
  assign w_offset       = address - BASE_ADDR;
  assign w_index        = w_offset[ADDR_WIDTH-1:2];
  assign w_lane         = w_offset[1:0];
  assign w_idx          = w_index[IDX_W-1:0];
  assign w_out_of_range = (address < BASE_ADDR) ||
                          ({2'b00, w_index} >= DEPTH_L);

  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
  assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_sext  = ~req_unsigned;

  // Per-size alignment check, store lane enables and load extension.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    w_wdata      = 32'h0;
    w_load       = 32'h0;
    case (req_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{write_data[7:0]}};
        w_load  = {{24{w_sext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        w_misaligned = w_lane[0];
        w_be         = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{write_data[15:0]}};
        w_load       = {{16{w_sext & w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        w_misaligned = (w_lane != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = write_data;
        w_load       = w_rword;
      end
      default: begin
        w_misaligned = 1'b1;
      end
    endcase
  end

  assign w_err = w_misaligned | w_out_of_range;
  assign w_we  = req_valid & ~reset & req_write & ~w_err;

  // Storage array; never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response register: one pulse per accepted request, all fields zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid   <= 1'b0;
      r_read_data    <= 32'h0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
    end else begin
      r_resp_valid   <= req_valid;
      r_misaligned   <= req_valid & w_misaligned;
      r_out_of_range <= req_valid & w_out_of_range;
      r_read_data    <= (req_valid && !req_write && !w_err) ? w_load : 32'h0;
    end
  end

  assign read_data    = r_read_data;
  assign resp_valid   = r_resp_valid;
  assign misaligned   = r_misaligned;
  assign out_of_range = r_out_of_range;

endmodule
